// File: rtl/register_file_mp_pkg.sv
// rf_pkg: default geometry of the multi-port register file and shared helpers.
package rf_pkg;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_RD   = 2;
  // popcount operates on a fixed-width vector; callers zero-extend up to this size
  localparam int RF_MAX_REGS = 64;

  function automatic int unsigned popcount(input logic [RF_MAX_REGS-1:0] v);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < RF_MAX_REGS; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction
endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, write port, reserve port and status.
interface register_file_mp_if
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_RD   = RF_NUM_RD
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_REGS-1:0]      busy;
  logic [ADDR_W:0]          busy_cnt;
  logic                     wr_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_valid, busy, busy_cnt, wr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_valid, busy, busy_cnt, wr_err
  );
endinterface

// File: rtl/register_file_mp_read_port.sv
// rf_read_port: one registered read port with range check, busy check and write bypass.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [NUM_REGS*DATA_W-1:0] i_regs,
  input  logic [NUM_REGS-1:0]        i_busy,
  input  logic                       i_wr_ok,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid
);
  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  logic              w_inrange;
  logic              w_bypass;
  logic              w_hit_busy;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_valid_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Select the addressed word and busy bit, then pick hold / zero / bypass / stored.
  always_comb begin
    w_word     = {DATA_W{1'b0}};
    w_hit_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_word     = w_word | (i_regs[i*DATA_W +: DATA_W] & {DATA_W{i_addr == ADDR_W'(i)}});
      w_hit_busy = w_hit_busy | (i_busy[i] & (i_addr == ADDR_W'(i)));
    end
    w_inrange = ({1'b0, i_addr} < LP_NREGS);
    w_bypass  = (BYPASS != 0) && i_wr_ok && (i_wr_addr == i_addr);
    if (!i_en) begin
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
    end else if (!w_inrange) begin
      w_data_nxt  = {DATA_W{1'b0}};
      w_valid_nxt = 1'b0;
    end else if (w_bypass) begin
      w_data_nxt  = i_wr_data;
      w_valid_nxt = 1'b1;
    end else begin
      w_data_nxt  = w_word;
      w_valid_nxt = !w_hit_busy;
    end
  end

  // Output register for this port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= {DATA_W{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read, single-write register file with a busy scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  register_file_mp_if.slave rf_bus
);
  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]        r_busy;
  logic [ADDR_W:0]            r_busy_cnt;
  logic                       r_wr_err;

  logic                       w_wr_inrange;
  logic                       w_wr_ok;
  logic                       w_rsv_legal;
  logic                       w_rsv_ok;
  logic                       w_rsv_busy;
  logic                       w_err;
  logic [NUM_REGS-1:0]        w_wr_sel;
  logic [NUM_REGS-1:0]        w_rsv_sel;
  logic [NUM_REGS-1:0]        w_busy_nxt;
  logic [RF_MAX_REGS-1:0]     w_busy_ext;
  logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
  logic [NUM_RD*DATA_W-1:0]   w_rd_data;
  logic [NUM_RD-1:0]          w_rd_valid;

  // Decode write/reserve legality and the next busy vector (reservation wins over clear).
  always_comb begin
    w_wr_sel    = {NUM_REGS{1'b0}};
    w_rsv_sel   = {NUM_REGS{1'b0}};
    w_regs_flat = {(NUM_REGS*DATA_W){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wr_sel[i]  = (rf_bus.wr_addr == ADDR_W'(i));
      w_rsv_sel[i] = (rf_bus.rsv_addr == ADDR_W'(i));
      w_regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
    end
    w_wr_inrange = ({1'b0, rf_bus.wr_addr} < LP_NREGS);
    w_wr_ok      = rf_bus.wr_en && w_wr_inrange &&
                   !((ZERO_REG != 0) && (rf_bus.wr_addr == {ADDR_W{1'b0}}));
    w_rsv_legal  = ({1'b0, rf_bus.rsv_addr} < LP_NREGS) &&
                   !((ZERO_REG != 0) && (rf_bus.rsv_addr == {ADDR_W{1'b0}}));
    w_rsv_ok     = rf_bus.rsv_en && w_rsv_legal;
    w_rsv_busy   = |(r_busy & w_rsv_sel);
    w_busy_nxt   = (r_busy & ~({NUM_REGS{w_wr_ok}} & w_wr_sel)) |
                   ({NUM_REGS{w_rsv_ok}} & w_rsv_sel);
    w_err        = (rf_bus.wr_en && !w_wr_inrange) ||
                   (rf_bus.rsv_en && (!w_rsv_legal || w_rsv_busy));
    w_busy_ext   = {RF_MAX_REGS{1'b0}};
    w_busy_ext[NUM_REGS-1:0] = w_busy_nxt;
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && w_wr_sel[i]) r_regs[i] <= rf_bus.wr_data;
      end
    end
  end

  // Scoreboard state and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= {NUM_REGS{1'b0}};
      r_busy_cnt <= {(ADDR_W+1){1'b0}};
      r_wr_err   <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= (ADDR_W+1)'(popcount(w_busy_ext));
      r_wr_err   <= w_err;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (rf_bus.rd_en[p]),
      .i_addr    (rf_bus.rd_addr[p*ADDR_W +: ADDR_W]),
      .i_regs    (w_regs_flat),
      .i_busy    (r_busy),
      .i_wr_ok   (w_wr_ok),
      .i_wr_addr (rf_bus.wr_addr),
      .i_wr_data (rf_bus.wr_data),
      .o_data    (w_rd_data[p*DATA_W +: DATA_W]),
      .o_valid   (w_rd_valid[p])
    );
  end

  assign rf_bus.rd_data  = w_rd_data;
  assign rf_bus.rd_valid = w_rd_valid;
  assign rf_bus.busy     = r_busy;
  assign rf_bus.busy_cnt = r_busy_cnt;
  assign rf_bus.wr_err   = r_wr_err;
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (12 registers, zero register, bypass enabled).
module tb_register_file_mp;
  localparam int NREGS = 12;

  typedef struct packed {
    logic [1:0][15:0] d;
    logic [1:0]       v;
    logic [11:0]      busy;
    logic [4:0]       cnt;
    logic             err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q [$];

  logic [15:0] m_mem  [NREGS];
  bit          m_busy [NREGS];
  logic [15:0] m_last [2];

  register_file_mp_if #(.NUM_REGS(NREGS), .ADDR_W(4), .DATA_W(16), .NUM_RD(2)) bus ();

  register_file_mp #(
    .NUM_REGS(NREGS), .ADDR_W(4), .DATA_W(16), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rf_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = 16'h0000;
      m_busy[i] = 1'b0;
    end
    m_last[0] = 16'h0000;
    m_last[1] = 16'h0000;
  endtask

  // One cycle of stimulus; the reference model predicts the outputs after the next edge.
  task automatic step(input logic [1:0] ren, input logic [3:0] a0, input logic [3:0] a1,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic re, input logic [3:0] ra);
    exp_t e;
    bit   wlegal;
    int   ad;
    int   cnt;
    @(negedge clk);
    bus.rd_en    = ren;
    bus.rd_addr  = {a1, a0};
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = ra;
    wlegal = we && (int'(wa) < NREGS) && (wa != 4'd0);
    for (int p = 0; p < 2; p++) begin
      ad = (p == 0) ? int'(a0) : int'(a1);
      if (!ren[p]) begin
        e.d[p] = m_last[p]; e.v[p] = 1'b0;
      end else if (ad >= NREGS) begin
        e.d[p] = 16'h0000;  e.v[p] = 1'b0;
      end else if (ad == 0) begin
        e.d[p] = 16'h0000;  e.v[p] = 1'b1;
      end else if (wlegal && int'(wa) == ad) begin
        e.d[p] = wd;        e.v[p] = 1'b1;
      end else begin
        e.d[p] = m_mem[ad]; e.v[p] = !m_busy[ad];
      end
      m_last[p] = e.d[p];
    end
    e.err = (we && int'(wa) >= NREGS) ||
            (re && ((int'(ra) >= NREGS) || (ra == 4'd0) ||
                    ((int'(ra) < NREGS) ? m_busy[int'(ra)] : 1'b0)));
    if (wlegal) begin
      m_mem[int'(wa)]  = wd;
      m_busy[int'(wa)] = 1'b0;
    end
    if (re && int'(ra) < NREGS && ra != 4'd0) m_busy[int'(ra)] = 1'b1;
    cnt = 0;
    for (int i = 0; i < NREGS; i++) begin
      e.busy[i] = m_busy[i];
      cnt += m_busy[i] ? 1 : 0;
    end
    e.cnt = 5'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
  endtask

  // Monitor: after every edge pop one prediction and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data0",  {16'h0, bus.rd_data[15:0]},  {16'h0, e.d[0]});
        chk("rd_data1",  {16'h0, bus.rd_data[31:16]}, {16'h0, e.d[1]});
        chk("rd_valid",  {30'h0, bus.rd_valid},       {30'h0, e.v});
        chk("busy",      {20'h0, bus.busy},           {20'h0, e.busy});
        chk("busy_cnt",  {27'h0, bus.busy_cnt},       {27'h0, e.cnt});
        chk("wr_err",    {31'h0, bus.wr_err},         {31'h0, e.err});
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.rd_en = 2'b00; bus.rd_addr = 8'h00; bus.wr_en = 1'b0; bus.wr_addr = 4'd0;
    bus.wr_data = 16'h0000; bus.rsv_en = 1'b0; bus.rsv_addr = 4'd0;
    model_reset();
    #12;
    chk("reset_rd_data",  bus.rd_data,               32'h0);
    chk("reset_rd_valid", {30'h0, bus.rd_valid},     32'h0);
    chk("reset_busy",     {20'h0, bus.busy},         32'h0);
    chk("reset_busy_cnt", {27'h0, bus.busy_cnt},     32'h0);
    chk("reset_wr_err",   {31'h0, bus.wr_err},       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // write r3, read it back
    step(2'b00, 4'd0, 4'd0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0);
    step(2'b01, 4'd3, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    // same-cycle write and dual read of r5 (bypass)
    step(2'b11, 4'd5, 4'd5, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    // reserve r7, read while busy, write clears, read again
    step(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7);
    step(2'b11, 4'd7, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    step(2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 16'h0042, 1'b0, 4'd0);
    step(2'b01, 4'd7, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    // out-of-range write and read
    step(2'b00, 4'd0, 4'd0, 1'b1, 4'd13, 16'hDEAD, 1'b0, 4'd0);
    step(2'b11, 4'd13, 4'd15, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    // reserve+write same register, then re-reserve
    step(2'b00, 4'd0, 4'd0, 1'b1, 4'd2, 16'h5555, 1'b1, 4'd2);
    step(2'b10, 4'd0, 4'd2, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2);
    // zero register: write dropped, reserve rejected, reads 0 valid
    step(2'b00, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0);
    step(2'b11, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    step(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd12);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
           ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)));
    end

    // reserve a few, then reset mid-cycle with a reserve pending
    step(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd4);
    step(2'b00, 4'd0, 4'd0, 1'b1, 4'd6, 16'h7777, 1'b1, 4'd6);
    step(2'b11, 4'd4, 4'd6, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd9;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h9999;
    #1;
    chk("mid_reset_busy",     {20'h0, bus.busy},     32'h0);
    chk("mid_reset_busy_cnt", {27'h0, bus.busy_cnt}, 32'h0);
    chk("mid_reset_rd_valid", {30'h0, bus.rd_valid}, 32'h0);
    chk("mid_reset_rd_data",  bus.rd_data,           32'h0);
    chk("mid_reset_wr_err",   {31'h0, bus.wr_err},   32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.rsv_en = 1'b0; bus.wr_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(2'b11, 4'd4, 4'd9, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    step(2'b11, 4'd6, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    idle();

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): NUM_REGS, 16, implemented registers; ADDR_W, 4, address width; DATA_W, 16, data width; NUM_RD, 2, read ports (1..4); ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes; BYPASS, 1, 1 = same-cycle write forwarded to reads.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 rd_en  input  NUM_RD  per-port read request.
REQ-005 rd_addr  input  NUM_RD*ADDR_W  per-port unsigned read address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-006 rd_data  output  NUM_RD*DATA_W  per-port registered read data.
REQ-007 rd_valid  output  NUM_RD  per-port: rd_data is a legal, non-busy value.
REQ-008 wr_en, wr_addr, wr_data  input  1, ADDR_W, DATA_W  single write port.
REQ-009 rsv_en, rsv_addr  input  1, ADDR_W  scoreboard reserve: marks a register busy (pending write).
REQ-010 busy  output  NUM_REGS  registered per-register busy bits.
REQ-011 busy_cnt  output  ADDR_W+1  registered count of set busy bits.
REQ-012 wr_err  output  1  one-cycle pulse: previous-cycle write or reserve was illegal.

Function
REQ-013 Read latency SHALL be 1 cycle: request in cycle N -> rd_data/rd_valid updated at edge ending N.
REQ-014 rd_en=0 on a port SHALL hold that port's rd_data and drive its rd_valid to 0.
REQ-015 Address >= NUM_REGS SHALL return rd_data=0, rd_valid=0, and leave storage unchanged.
REQ-016 Reading a busy register SHALL return stored data with rd_valid=0 (consumer stalls).
REQ-017 Ports SHALL be independent; any number of ports SHALL read the same address in one cycle.
REQ-018 Write SHALL update storage at the edge; write to address >= NUM_REGS, or to register 0 when ZERO_REG=1, SHALL be dropped, and wr_err SHALL pulse next cycle only for out-of-range.
REQ-019 Read and write to same address same cycle: BYPASS=1 -> rd_data=wr_data, rd_valid=1 (write clears busy); BYPASS=0 -> old data, rd_valid reflects busy before the write.
REQ-020 Legal write SHALL clear busy[wr_addr]; legal reserve SHALL set busy[rsv_addr].
REQ-021 Reserve and write to same address same cycle SHALL leave busy=1 (new reservation wins).
REQ-022 Reserve of an already-busy register SHALL keep busy=1 and pulse wr_err; reserve out of range or of register 0 with ZERO_REG=1 SHALL be ignored with wr_err pulse.
REQ-023 busy_cnt SHALL equal popcount(busy) every cycle, never wrap (max NUM_REGS).
REQ-024 ZERO_REG=1: register 0 SHALL always read 0, rd_valid=1, busy[0]=0.

Reset
REQ-025 rst_n low SHALL immediately clear all registers, busy, busy_cnt, rd_data, rd_valid, wr_err to 0.
REQ-026 Reset asserted mid-operation SHALL discard any same-cycle write/reserve; first legal access is the first edge with rst_n high.

Structure
REQ-027 A shared package rf_pkg SHALL hold default width/depth constants and the popcount function.
REQ-028 One sub-module rf_read_port (address check, busy check, bypass mux, output register) SHALL be instantiated NUM_RD times by generate.
REQ-029 Storage SHALL be a flop array with asynchronous reset; no memory-init file.

Verification
REQ-030 Reset, write r3=0x1234, read r3 on port0 next cycle -> rd_data0=0x1234, rd_valid0=1 one cycle later.
REQ-031 Same cycle wr r5=0xBEEF and rd r5 both ports: BYPASS=1 -> both 0xBEEF valid; BYPASS=0 -> both 0x0000 valid.
REQ-032 rsv r7, read r7 -> rd_valid=0, busy_cnt=1; write r7=0x0042 -> busy_cnt=0, next read 0x0042 valid.
REQ-033 NUM_REGS=12: write addr 13 -> wr_err=1 one cycle, read addr 13 -> data 0 valid 0, no register changed.
REQ-034 Reserve r2 and write r2 same cycle -> busy[2]=1 after; second reserve r2 -> wr_err pulse, busy_cnt unchanged.
REQ-035 Reserve 3 registers then pulse rst_n low mid-cycle -> busy=0, busy_cnt=0, all rd_valid=0 immediately, all reads return 0.
